neur_acc_unit: RTL
==================

Name: neur_acc_unit

Overview:
- Upstream accumulation stage for the neuron output/requantisation unit.
- Four output-neuron lanes each accumulate a signed dot product of four int8 activations with mixed-precision weights (int8, int4 or int2) over a programmed number of beats.
- Each accumulator is seeded with a per-lane int32 bias.
- Hands the four int32 sums to the output stage through a valid/ready handshake.

Parameters:
- LANES, 4, number of output neurons accumulated in parallel; fixed at 4, matching the output stage.
- LEN_W, 16, width of the beat-count register.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle pulse; load bias, latch len/prec, enter ACC
- len_i  input  LEN_W  number of MAC beats for this neuron group (0 allowed)
- prec_i  input  2  weight precision: 00 int8, 01 int4, 10 int2, 11 reserved (treated as int8)
- bias_i  input  32 x LANES  per-lane signed bias
- mac_valid_i  input  1  activation/weight beat valid
- mac_ready_o  output  1  beat accepted when valid&ready
- act_i  input  32  four int8 activations, act k = act_i[8k+:8]
- wgt_i  input  32 x LANES  per-lane weights; int8: w k=[8k+:8]; int4: w k=[4k+:4]; int2: w k=[2k+:2]; unused upper bits ignored
- res_valid_o  output  1  accumulated results available
- res_ready_i  input  1  downstream accepts results
- acc_o  output  32 x LANES  signed accumulated sums, stable while res_valid_o
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_ni low):
  - State IDLE.
  - acc_o, res_valid_o, mac_ready_o, busy_o, beat counter and product pipeline register all 0.
- FSM states IDLE, ACC, DRAIN, DONE.
- IDLE:
  - start_i -> acc[j]=bias_i[j]; cnt=len_i; prec latched.
  - Next state ACC if len_i!=0, else DONE directly, with acc = bias.
- ACC:
  - mac_ready_o=1.
  - Each accepted beat computes p[j] = sum over k=0..3 of sext(act_k) * sext(w_jk), width 18 bits signed, and registers it (pipeline stage, 1 cycle).
  - The registered p[j] is added to acc[j] on the next cycle; sign extended to 32 bits, two's-complement wrap.
  - cnt decrements per accepted beat. When the last beat is accepted (cnt==1 and accept): ready drops the next cycle; go to DRAIN.
  - Idle cycles with mac_valid_i low do not advance anything.
- DRAIN: one cycle; the final product is added. Next state DONE.
- DONE:
  - res_valid_o=1; acc_o holds.
  - res_valid_o&res_ready_i -> IDLE, res_valid_o drops the next cycle.
  - Results from the prior group are never overwritten before the handshake.
- Latency: res_valid_o rises 2 cycles after the last accepted beat; 1 cycle after start_i when len_i=0.
- start_i outside IDLE is ignored. Reset mid-operation aborts immediately; no partial results are presented.
- Weights are signed in all modes: int4 range -8..7, int2 range -2..1. prec latched at start; changes on prec_i mid-group have no effect.
- Max beats 2^LEN_W-1. Accumulator overflow wraps unless the optional feature is enabled.

Optional Feature:
- NEUR_ACC_SAT_EN defined: each acc addition saturates to 0x7FFFFFFF / 0x80000000 on signed overflow, and a sticky per-lane sat_o[LANES] output port exists; it is cleared at start_i and reset.
- Not defined: plain wrapping add; no sat_o port.

Test Plan:
- int8:
  - Stimulus: start len=1, bias all 0, act=0x01020304 (a3=1,a2=2,a1=3,a0=4), lane0 wgt=0x01010101, lane1 wgt=0xFFFFFFFF.
  - Required: acc_o lane0=10, lane1=-10; res_valid_o 2 cycles after the beat.
- int4:
  - Stimulus: len=2, bias lane0=100, act=0x7F7F7F7F, wgt lane0=0x00008888 (all -8) both beats.
  - Required: acc0 = 100 + 2*(4*127*-8) = -8028.
- int2:
  - Stimulus: len=3, act=0x80808080, wgt lane2=0x000000AA (all -2).
  - Required: acc2 = 3*(4*-128*-2) = 3072.
  - Additionally, mac_valid_i gaps between beats give an identical result.
- len=0, bias lane3=-5:
  - Required: res_valid_o one cycle after start, acc3=-5.
  - Hold res_ready_i=0 for 10 cycles: results stable; start_i ignored while waiting.
- Back-pressure/reset:
  - Reset asserted mid-ACC after 1 of 4 beats -> all outputs 0 immediately, state IDLE.
  - A new start then completes normally.
- NEUR_ACC_SAT_EN:
  - Stimulus: bias=0x7FFFFF00, len=1, act=0x7F7F7F7F, wgt=0x7F7F7F7F.
  - Required: acc saturates at 0x7FFFFFFF, sat_o set; wraps to a negative value without the macro.

Source files
------------

// File: rtl/neur_acc_unit.sv
// Four-lane mixed-precision (int8/int4/int2 weights) dot-product accumulator seeded with per-lane bias.
// Optional macro NEUR_ACC_SAT_EN: saturating accumulation and a sticky per-lane sat_o port.
module neur_acc_unit #(
    parameter int LANES = 4,
    parameter int LEN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [1:0]            prec_i,
    input  logic [32*LANES-1:0]   bias_i,
    input  logic                  mac_valid_i,
    output logic                  mac_ready_o,
    input  logic [31:0]           act_i,
    input  logic [32*LANES-1:0]   wgt_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [32*LANES-1:0]   acc_o,
    output logic                  busy_o
`ifdef NEUR_ACC_SAT_EN
    ,
    output logic [LANES-1:0]      sat_o
`endif
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t                 state;
    logic [LEN_W-1:0]       cnt;
    logic [1:0]             prec;
    logic [31:0]            acc       [LANES];
    logic [31:0]            acc_raw   [LANES];
    logic [31:0]            acc_next  [LANES];
    logic signed [17:0]     prod      [LANES];
    logic signed [17:0]     prod_next [LANES];
    logic                   prod_vld;
    logic                   accept;
`ifdef NEUR_ACC_SAT_EN
    logic [LANES-1:0]       ovf;
`endif

    // Narrow weights are sign-extended so every mode feeds the same 8x8 signed multiplier.
    function automatic logic signed [7:0] weight(input logic [31:0] w, input logic [1:0] pr, input int k);
        case (pr)
            2'b01:   return {{4{w[4*k+3]}}, w[4*k+:4]};
            2'b10:   return {{6{w[2*k+1]}}, w[2*k+:2]};
            default: return w[8*k+:8];
        endcase
    endfunction

    function automatic logic signed [17:0] term(input logic signed [7:0] a, input logic signed [7:0] w);
        logic signed [15:0] m;
        m = a * w;
        return {{2{m[15]}}, m};
    endfunction

    assign accept = mac_ready_o & mac_valid_i;

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            prod_next[j] = '0;
            for (int k = 0; k < 4; k++)
                prod_next[j] = prod_next[j] + term(act_i[8*k+:8], weight(wgt_i[32*j+:32], prec, k));
        end
    end

    // Overflow only possible when both operands share a sign and the result flips it.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            acc_raw[j] = acc[j] + {{14{prod[j][17]}}, prod[j]};
`ifdef NEUR_ACC_SAT_EN
            ovf[j] = (acc[j][31] == prod[j][17]) && (acc_raw[j][31] != acc[j][31]);
            acc_next[j] = ovf[j] ? (acc[j][31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_raw[j];
`else
            acc_next[j] = acc_raw[j];
`endif
        end
    end

    always_comb begin
        acc_o = '0;
        for (int j = 0; j < LANES; j++)
            acc_o[32*j+:32] = acc[j];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            prec        <= '0;
            prod_vld    <= 1'b0;
            mac_ready_o <= 1'b0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                acc[j]  <= '0;
                prod[j] <= '0;
            end
`ifdef NEUR_ACC_SAT_EN
            sat_o       <= '0;
`endif
        end else begin
            prod_vld <= accept;
            if (accept) begin
                for (int j = 0; j < LANES; j++)
                    prod[j] <= prod_next[j];
            end
            if (prod_vld) begin
                for (int j = 0; j < LANES; j++)
                    acc[j] <= acc_next[j];
`ifdef NEUR_ACC_SAT_EN
                sat_o <= sat_o | ovf;
`endif
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int j = 0; j < LANES; j++)
                            acc[j] <= bias_i[32*j+:32];
                        cnt    <= len_i;
                        prec   <= prec_i;
                        busy_o <= 1'b1;
`ifdef NEUR_ACC_SAT_EN
                        sat_o  <= '0;
`endif
                        if (len_i != '0) begin
                            state       <= ACC;
                            mac_ready_o <= 1'b1;
                        end else begin
                            state       <= DONE;
                            res_valid_o <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            mac_ready_o <= 1'b0;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    res_valid_o <= 1'b1;
                end
                DONE: begin
                    if (res_ready_i) begin
                        state       <= IDLE;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
